// File: rtl/pid_plant_model.sv
// Discrete-time first-order lag plant with optional transport delay, updated once
// every SAMPLE_DIV clocks; closes the PID loop in simulation and on hardware.
module pid_plant_model #(
  parameter int unsigned       SAMPLE_DIV = 16,
  parameter int unsigned       DELAY      = 2,
  parameter int unsigned       U_SHIFT    = 2,
  parameter int unsigned       TAU_SHIFT  = 3,
  parameter logic signed [9:0] Y_INIT     = 10'sd0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic signed [14:0] uk0,
  output logic signed [9:0]  y,
  output logic               y_valid,
  output logic               busy,
  output logic [1:0]         state_dbg
);

  // Output handshake: there is no ready. y_valid is high for exactly one cycle,
  // the first cycle y carries a new value; y then holds until the next pulse.

  typedef enum logic [1:0] {IDLE, CAPTURE, CALC, UPDATE} state_t;

  localparam logic [15:0] DIV_LAST = 16'(SAMPLE_DIV - 1);

  state_t             state, state_nx;
  logic [15:0]        div;
  logic               tick;
  logic signed [14:0] u_s, u_d, dly_out;
  logic signed [15:0] err, step;
  logic signed [16:0] sum;
  logic signed [9:0]  y_sat;

  assign tick      = en && (div == DIV_LAST);
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             div <= '0;
    else if (!en || tick)   div <= '0;
    else                    div <= div + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // A tick outside IDLE can only happen with an illegal SAMPLE_DIV; it is dropped.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (tick) state_nx = CAPTURE;
      CAPTURE: state_nx = CALC;
      CALC:    state_nx = UPDATE;
      UPDATE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  generate
    if (DELAY > 0) begin : g_dly
      localparam int PW = ($clog2(DELAY) > 0) ? $clog2(DELAY) : 1;
      localparam logic [PW-1:0] PTR_LAST = PW'(DELAY - 1);
      logic signed [14:0] dly_mem [2**PW];
      logic [PW-1:0]      wr_ptr;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          wr_ptr <= '0;
          for (int i = 0; i < 2**PW; i++) dly_mem[i] <= '0;
        end else if (state == CAPTURE) begin
          dly_mem[wr_ptr] <= u_s;
          wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
        end
      end

      // Read-before-write: the slot about to be overwritten holds the sample from DELAY ticks ago.
      assign dly_out = dly_mem[wr_ptr];
    end else begin : g_nodly
      assign dly_out = u_s;
    end
  endgenerate

  assign err = {u_d[14], u_d} - {{6{y[9]}}, y};
  assign sum = {step[15], step} + {{7{y[9]}}, y};

  always_comb begin
    y_sat = sum[9:0];
    if (sum > 17'sd511)       y_sat = 10'sd511;
    else if (sum < -17'sd512) y_sat = -10'sd512;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      u_s     <= '0;
      u_d     <= '0;
      step    <= '0;
      y       <= Y_INIT;
      y_valid <= 1'b0;
    end else begin
      y_valid <= 1'b0;
      case (state)
        IDLE:    if (tick) u_s <= uk0 >>> U_SHIFT;
        CAPTURE: u_d <= dly_out;
        CALC:    step <= err >>> TAU_SHIFT;
        UPDATE: begin
          y       <= y_sat;
          y_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pid_plant_model.sv
// Closed-form plant reference checked against three DUT configurations sharing one
// stimulus stream: no delay, two-sample delay, and unity lag for saturation.
module tb_pid_plant_model;

  localparam int SD = 16;
  localparam logic [1:0] ST_CALC   = 2'd2;
  localparam logic [1:0] ST_UPDATE = 2'd3;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               en;
  logic signed [14:0] uk0;

  logic signed [9:0] y0, y2, ys;
  logic              v0, v2, vs, b0, b2, bs;
  logic [1:0]        s0, s2, ss;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  logic signed [9:0]  exp0[$], exp2[$], exps[$];
  int                 hist2[$];
  int                 ym0, ym2, yms;

  pid_plant_model #(.SAMPLE_DIV(SD), .DELAY(0), .U_SHIFT(2), .TAU_SHIFT(3), .Y_INIT(10'sd0)) d0 (
    .clk(clk), .rst_n(rst_n), .en(en), .uk0(uk0), .y(y0), .y_valid(v0), .busy(b0), .state_dbg(s0));
  pid_plant_model #(.SAMPLE_DIV(SD), .DELAY(2), .U_SHIFT(2), .TAU_SHIFT(3), .Y_INIT(10'sd0)) d2 (
    .clk(clk), .rst_n(rst_n), .en(en), .uk0(uk0), .y(y2), .y_valid(v2), .busy(b2), .state_dbg(s2));
  pid_plant_model #(.SAMPLE_DIV(SD), .DELAY(0), .U_SHIFT(2), .TAU_SHIFT(0), .Y_INIT(10'sd0)) ds (
    .clk(clk), .rst_n(rst_n), .en(en), .uk0(uk0), .y(ys), .y_valid(vs), .busy(bs), .state_dbg(ss));

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  function automatic int plant(input int yp, input int ud, input int tau);
    int s;
    s = yp + ((ud - yp) >>> tau);
    if (s > 511)  s = 511;
    if (s < -512) s = -512;
    return s;
  endfunction

  task automatic model_reset();
    ym0 = 0; ym2 = 0; yms = 0;
    hist2 = '{0, 0};
    exp0.delete(); exp2.delete(); exps.delete();
  endtask

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic issue(input logic signed [14:0] u);
    int us, ud;
    uk0 = u;
    us  = int'(u) >>> 2;
    ym0 = plant(ym0, us, 3);
    exp0.push_back(10'(ym0));
    hist2.push_back(us);
    ud  = hist2.pop_front();
    ym2 = plant(ym2, ud, 3);
    exp2.push_back(10'(ym2));
    yms = plant(yms, us, 0);
    exps.push_back(10'(yms));
  endtask

  task automatic wait_pulse(output int stamp);
    stamp = -1;
    for (int i = 0; i < 4 * SD + 8; i++) begin
      @(negedge clk);
      if (v0) begin
        stamp = cyc;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL pulse_timeout: no y_valid within %0d cycles (cycle %0d)", 4 * SD + 8, cyc);
  endtask

  task automatic wait_state(input logic [1:0] st);
    for (int i = 0; i < 4 * SD + 8; i++) begin
      @(negedge clk);
      if (s0 == st) return;
    end
    checks++;
    errors++;
    $display("FAIL state_timeout: state %0d not reached (cycle %0d)", st, cyc);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (v0) begin
        if (exp0.size() == 0) chk("d0_unexpected_pulse", 1, 0);
        else chk("d0_y", int'(y0), int'(exp0.pop_front()));
      end
      if (v2) begin
        if (exp2.size() == 0) chk("d2_unexpected_pulse", 1, 0);
        else chk("d2_y", int'(y2), int'(exp2.pop_front()));
      end
      if (vs) begin
        if (exps.size() == 0) chk("ds_unexpected_pulse", 1, 0);
        else chk("ds_y", int'(ys), int'(exps.pop_front()));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int t_en, p, p_prev, cnt;
    logic signed [14:0] u;

    rst_n = 1'b0;
    en    = 1'b0;
    uk0   = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_y0", int'(y0), 0);   chk("reset_y2", int'(y2), 0);   chk("reset_ys", int'(ys), 0);
    chk("reset_valid", int'({v0, v2, vs}), 0);
    chk("reset_busy", int'({b0, b2, bs}), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Step response, held input.
    issue(15'sd1400);
    en = 1'b1;
    t_en = cyc;
    wait_pulse(p);
    chk("first_pulse_cycles", p - t_en + 1, SD + 4);
    chk("step_d0_1", int'(y0), 43);
    chk("step_d2_1", int'(y2), 0);
    p_prev = p;
    issue(15'sd1400);
    wait_pulse(p);
    chk("period_1", p - p_prev, SD);
    chk("step_d0_2", int'(y0), 81);
    chk("step_d2_2", int'(y2), 0);
    p_prev = p;
    issue(15'sd1400);
    wait_pulse(p);
    chk("period_2", p - p_prev, SD);
    chk("step_d2_3", int'(y2), 43);
    issue(15'sd1400);
    wait_pulse(p);
    chk("step_d2_4", int'(y2), 81);

    // Enable dropped while an update is in CALC.
    issue(15'sd1400);
    wait_state(ST_CALC);
    en = 1'b0;
    wait_pulse(p);
    cnt = 0;
    for (int i = 0; i < 3 * SD; i++) begin
      @(negedge clk);
      if (v0 || v2 || vs) cnt++;
    end
    chk("pulses_while_disabled", cnt, 0);
    issue(15'sd1400);
    en = 1'b1;
    t_en = cyc;
    wait_pulse(p);
    chk("reenable_pulse_cycles", p - t_en + 1, SD + 4);

    // Reset asserted during UPDATE, then delay buffer must come back empty.
    en = 1'b0;
    do_reset();
    issue(15'sd1400);
    en = 1'b1;
    wait_pulse(p);
    issue(15'sd1400);
    wait_pulse(p);
    issue(15'sd1400);
    wait_state(ST_UPDATE);
    chk("pre_reset_y0", int'(y0), 81);
    rst_n = 1'b0;
    #1;
    chk("midrst_y0", int'(y0), 0);
    chk("midrst_valid", int'({v0, v2, vs}), 0);
    chk("midrst_busy", int'({b0, b2, bs}), 0);
    model_reset();
    issue(15'sd1400);
    @(negedge clk);
    rst_n = 1'b1;
    t_en = cyc;
    wait_pulse(p);
    chk("post_reset_pulse_cycles", p - t_en + 1, SD + 4);
    chk("post_reset_d2_1", int'(y2), 0);
    issue(15'sd1400);
    wait_pulse(p);
    chk("post_reset_d2_2", int'(y2), 0);
    issue(15'sd1400);
    wait_pulse(p);
    chk("post_reset_d2_3", int'(y2), 43);

    // Negative input rounds toward minus infinity.
    en = 1'b0;
    do_reset();
    issue(-15'sd1400);
    en = 1'b1;
    wait_pulse(p);
    chk("neg_d0_1", int'(y0), -44);

    // Randomized input sequence, with extremes mixed in.
    for (int n = 0; n < 24; n++) begin
      case ($urandom_range(0, 5))
        0:       u = 15'sh3FFF;
        1:       u = -15'sh4000;
        default: u = 15'($urandom_range(0, 32767));
      endcase
      issue(u);
      wait_pulse(p);
    end

    // Saturation on the unity-lag instance.
    issue(15'sd16383);
    wait_pulse(p);
    chk("sat_hi_1", int'(ys), 511);
    issue(15'sd16383);
    wait_pulse(p);
    chk("sat_hi_2", int'(ys), 511);
    issue(-15'sd16384);
    wait_pulse(p);
    chk("sat_lo", int'(ys), -512);

    en = 1'b0;
    repeat (SD) @(negedge clk);
    chk("leftover_exp0", exp0.size(), 0);
    chk("leftover_exp2", exp2.size(), 0);
    chk("leftover_exps", exps.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
